// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I pipeline control slice: wait-state FSM states,
// hazard-kind trace encoding and architectural register constants.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } pipe_state_t;

  typedef enum logic [1:0] {
    HZ_NONE    = 2'd0,
    HZ_LOADUSE = 2'd1,
    HZ_BRANCH  = 2'd2,
    HZ_FREEZE  = 2'd3
  } hazard_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/rv32i_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module rv32i_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges memory wait
// states, EX-resolved branches and load-use hazards into per-stage enables.
module rv32i_pipe_ctrl
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output pipe_state_t      state,
  output hazard_t          hazard
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  pipe_state_t       state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memwait;
  logic              loaduse;
  logic              wait_clr;

  // Handshake: a MEM-stage request (mem_req_mem) completes in the cycle the
  // memory raises mem_ready; every cycle with the request up and ready low
  // is a wait state that freezes the whole pipeline.
  assign memwait = mem_req_mem & ~mem_ready;
  assign loaduse = memread_ex & (rd_ex != REG_X0) &
                   ((rd_ex == rs1_id) | (rd_ex == rs2_id));

  always_comb begin
    hazard = HZ_NONE;
    if (memwait)              hazard = HZ_FREEZE;
    else if (branch_taken_ex) hazard = HZ_BRANCH;
    else if (loaduse)         hazard = HZ_LOADUSE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // A withdrawn request and a completed one both leave MEM_WAIT the same way.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (memwait) state_next = MEM_WAIT;
      MEM_WAIT: if (!memwait) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else begin
      case (hazard)
        HZ_FREEZE: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
        end
        HZ_BRANCH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        HZ_LOADUSE: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Counting from zero in RUN makes the first wait cycle land on 1.
  assign wait_clr = rst | ((state == MEM_WAIT) & ~memwait);

  rv32i_sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (wait_clr),
    .inc (memwait),
    .q   (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if ((state == MEM_WAIT) && memwait &&
                 (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

  rv32i_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_write),
    .q   (stall_cnt)
  );

  rv32i_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hazard == HZ_BRANCH),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl built with MEM_TIMEOUT=4, CNT_W=4.
module tb_rv32i_pipe_ctrl;
  import rv32i_pkg::*;

  localparam int MT = 4;
  localparam int CW = 4;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] O_NONE   = 7'b1111100;
  localparam logic [6:0] O_LU     = 7'b0011101;
  localparam logic [6:0] O_BR     = 7'b1111111;
  localparam logic [6:0] O_FRZ    = 7'b0000000;
  localparam logic [6:0] O_RST    = 7'b0000011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic memread_ex, branch_taken_ex, mem_req_mem, mem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  pipe_state_t state;
  hazard_t hazard;

  int n_total = 0;
  int n_bad   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  rv32i_pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state(state), .hazard(hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        memread, branch, memreq, ready;
    logic [6:0]  outs;
    int          stall_inc;
    int          flush_inc;
    pipe_state_t nstate;
  } vec_t;

  vec_t vecs[11];

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [6:0] outs_now();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
            if_id_flush, id_ex_flush};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic rq, input logic rdy);
    rs1_id = rs1; rs2_id = rs2; rd_ex = rd;
    memread_ex = mr; branch_taken_ex = br; mem_req_mem = rq; mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  initial begin
    vecs[0]  = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 0, 0, RUN};
    vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   1, 0, RUN};
    vecs[2]  = '{5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   1, 0, RUN};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 0, 0, RUN};
    vecs[4]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 0, 0, RUN};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   0, 1, RUN};
    vecs[6]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   0, 1, RUN};
    vecs[7]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ,  1, 0, MEM_WAIT};
    vecs[8]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, O_LU,   1, 0, RUN};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 0, 0, RUN};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE, 0, 0, RUN};

    // Reset
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("reset outs", 32'(outs_now()), 32'(O_RST));
    tick();
    tick();
    check("reset outs held", 32'(outs_now()), 32'(O_RST));
    rst = 1'b0;
    #1;
    check("reset state", 32'(state), 32'(RUN));
    check("reset timeout", 32'(mem_timeout), 32'd0);
    check_regs("reset");

    // Single-cycle vector table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].memread,
            vecs[i].branch, vecs[i].memreq, vecs[i].ready);
      #1;
      check($sformatf("vec%0d outs", i), 32'(outs_now()), 32'(vecs[i].outs));
      exp_stall = sat(exp_stall + vecs[i].stall_inc);
      exp_flush = sat(exp_flush + vecs[i].flush_inc);
      tick();
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].nstate));
      check_regs($sformatf("vec%0d", i));
    end

    // Three wait states with a branch held; branch acts once ready arrives
    drive(0, 0, 0, 0, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("wait%0d outs", c), 32'(outs_now()), 32'(O_FRZ));
      tick();
      check($sformatf("wait%0d state", c), 32'(state), 32'(MEM_WAIT));
    end
    exp_stall = sat(exp_stall + 3);
    check_regs("after wait");
    mem_ready = 1'b1;
    #1;
    check("ready cycle outs", 32'(outs_now()), 32'(O_BR));
    tick();
    exp_flush = sat(exp_flush + 1);
    check("ready state", 32'(state), 32'(RUN));
    check_regs("after ready");

    // Withdrawn request: back to RUN, no timeout
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    exp_stall = sat(exp_stall + 2);
    mem_req_mem = 1'b0;
    #1;
    check("withdraw outs", 32'(outs_now()), 32'(O_NONE));
    tick();
    check("withdraw state", 32'(state), 32'(RUN));
    check("withdraw timeout", 32'(mem_timeout), 32'd0);
    check_regs("withdraw");

    // Timeout: memory never ready; stall_cnt also runs into saturation
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_stall = sat(exp_stall + 1);
      check($sformatf("timeout c%0d", c), 32'(mem_timeout), (c >= MT) ? 32'd1 : 32'd0);
    end
    check("sat state", 32'(state), 32'(MEM_WAIT));
    check_regs("saturated");
    check("sat value", 32'(stall_cnt), 32'hF);

    // Reset in the middle of a wait
    rst = 1'b1;
    #1;
    check("mid-wait reset outs", 32'(outs_now()), 32'(O_RST));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check("post reset state", 32'(state), 32'(RUN));
    check("post reset timeout", 32'(mem_timeout), 32'd0);
    check_regs("post reset");
    tick();
    check("post reset idle state", 32'(state), 32'(RUN));
    check_regs("post reset idle");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
